// File: rtl/ucsbece154b_branch_predictor.sv
// GShare direction predictor paired with a direct-mapped BTB for the fetch stage.
// Lookups are purely combinational; training comes from execute-stage resolution.
module ucsbece154b_branch_predictor #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [31:0]             PCF_i,
    output logic                    BranchTaken_o,
    output logic [31:0]             BTBtarget_o,
    output logic [NUM_GHR_BITS-1:0] PHTindex_o,

    input  logic [31:0]             PCE_i,
    input  logic                    BranchE_i,
    input  logic                    JalE_i,
    input  logic                    PCSrcE_i,
    input  logic [31:0]             BranchTargetE_i,
    input  logic [NUM_GHR_BITS-1:0] PHTindexE_i
);

    localparam int IDXB        = $clog2(NUM_BTB_ENTRIES);
    localparam int TAGW        = 30 - IDXB;
    localparam int PHT_ENTRIES = 1 << NUM_GHR_BITS;

    logic [NUM_GHR_BITS-1:0]    ghr_q, ghr_d;
    logic [1:0]                 pht_q    [PHT_ENTRIES];
    logic [1:0]                 pht_d    [PHT_ENTRIES];
    logic [NUM_BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_BTB_ENTRIES-1:0] j_q, j_d;
    logic [TAGW-1:0]            tag_q    [NUM_BTB_ENTRIES];
    logic [TAGW-1:0]            tag_d    [NUM_BTB_ENTRIES];
    logic [31:0]                target_q [NUM_BTB_ENTRIES];
    logic [31:0]                target_d [NUM_BTB_ENTRIES];

    logic [IDXB-1:0] f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;
    logic [IDXB-1:0] e_idx;
    logic [TAGW-1:0] e_tag;
    logic [1:0]      pht_cur;

    // Byte-offset bits of word-aligned PCs carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF_i[1:0], PCE_i[1:0]};

    assign f_idx = PCF_i[IDXB+1:2];
    assign f_tag = PCF_i[31:IDXB+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign PHTindex_o    = PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
    assign BranchTaken_o = f_hit && (j_q[f_idx] || pht_q[PHTindex_o][1]);
    assign BTBtarget_o   = target_q[f_idx];

    assign e_idx   = PCE_i[IDXB+1:2];
    assign e_tag   = PCE_i[31:IDXB+2];
    assign pht_cur = pht_q[PHTindexE_i];

    always_comb begin
        ghr_d    = ghr_q;
        pht_d    = pht_q;
        valid_d  = valid_q;
        j_d      = j_q;
        tag_d    = tag_q;
        target_d = target_q;

        if (BranchE_i || JalE_i) begin
            valid_d[e_idx]  = 1'b1;
            tag_d[e_idx]    = e_tag;
            target_d[e_idx] = BranchTargetE_i;
            j_d[e_idx]      = JalE_i;
        end

        // Saturating 2-bit counter; history shifts only for conditional branches.
        if (BranchE_i) begin
            if (PCSrcE_i && (pht_cur != 2'b11)) begin
                pht_d[PHTindexE_i] = pht_cur + 2'd1;
            end else if (!PCSrcE_i && (pht_cur != 2'b00)) begin
                pht_d[PHTindexE_i] = pht_cur - 2'd1;
            end
            ghr_d = {ghr_q[NUM_GHR_BITS-2:0], PCSrcE_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            ghr_q   <= ghr_d;
            valid_q <= valid_d;
            pht_q   <= pht_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            j_q      <= j_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Self-checking bench for the gshare/BTB predictor: directed scenarios plus
// randomized traffic compared against an arithmetic reference model.
module tb_ucsbece154b_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PCF_i;
    logic        BranchTaken_o;
    logic [31:0] BTBtarget_o;
    logic [4:0]  PHTindex_o;
    logic [31:0] PCE_i;
    logic        BranchE_i;
    logic        JalE_i;
    logic        PCSrcE_i;
    logic [31:0] BranchTargetE_i;
    logic [4:0]  PHTindexE_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid  [32];
    int unsigned m_tag    [32];
    logic [31:0] m_target [32];
    bit          m_j      [32];
    int          m_pht    [32];
    int          m_ghr;

    ucsbece154b_branch_predictor #(
        .NUM_BTB_ENTRIES(32),
        .NUM_GHR_BITS(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PCF_i(PCF_i),
        .BranchTaken_o(BranchTaken_o),
        .BTBtarget_o(BTBtarget_o),
        .PHTindex_o(PHTindex_o),
        .PCE_i(PCE_i),
        .BranchE_i(BranchE_i),
        .JalE_i(JalE_i),
        .PCSrcE_i(PCSrcE_i),
        .BranchTargetE_i(BranchTargetE_i),
        .PHTindexE_i(PHTindexE_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_predict(input logic [31:0] pc, output bit t,
                                          output logic [4:0] pi, output logic [31:0] tg);
        int bi;
        int p;
        bi = int'((pc / 4) % 32);
        p  = bi ^ m_ghr;
        t  = m_valid[bi] && (m_tag[bi] == pc / 128) && (m_j[bi] || m_pht[p] >= 2);
        pi = 5'(p);
        tg = m_target[bi];
    endfunction

    function automatic void model_update();
        int bi;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 0;
                m_pht[i]   = 1;
            end
            m_ghr = 0;
        end else begin
            if (BranchE_i || JalE_i) begin
                bi           = int'((PCE_i / 4) % 32);
                m_valid[bi]  = 1;
                m_tag[bi]    = PCE_i / 128;
                m_target[bi] = BranchTargetE_i;
                m_j[bi]      = JalE_i;
            end
            if (BranchE_i) begin
                if (PCSrcE_i) m_pht[PHTindexE_i] = (m_pht[PHTindexE_i] == 3) ? 3 : m_pht[PHTindexE_i] + 1;
                else          m_pht[PHTindexE_i] = (m_pht[PHTindexE_i] == 0) ? 0 : m_pht[PHTindexE_i] - 1;
                m_ghr = (m_ghr * 2 + (PCSrcE_i ? 1 : 0)) % 32;
            end
        end
    endfunction

    task automatic drive_e(input bit rst, input logic [31:0] pce, input bit br, input bit jl,
                           input bit tk, input logic [31:0] tgt, input logic [4:0] pie);
        reset           = rst;
        PCE_i           = pce;
        BranchE_i       = br;
        JalE_i          = jl;
        PCSrcE_i        = tk;
        BranchTargetE_i = tgt;
        PHTindexE_i     = pie;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        reset     = 1'b0;
        BranchE_i = 1'b0;
        JalE_i    = 1'b0;
        PCSrcE_i  = 1'b0;
    endtask

    task automatic do_reset();
        drive_e(1, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] pc;
        do_reset();
        do_reset();
        PCF_i = 32'h20;
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_taken: got %0b expected 0", BranchTaken_o);
        end
        n_checks++;
        if (PHTindex_o !== 5'd8) begin
            n_fail++;
            $display("[TB] FAIL reset_phtidx: got %0d expected 8", PHTindex_o);
        end
        for (int i = 0; i < 6; i++) begin
            pc    = $urandom & 32'hFFFF_FFFC;
            PCF_i = pc;
            #1;
            n_checks++;
            if (BranchTaken_o !== 1'b0 || PHTindex_o !== 5'((pc / 4) % 32)) begin
                n_fail++;
                $display("[TB] FAIL reset_rand_pc %h: got taken=%0b idx=%0d expected taken=0 idx=%0d",
                         pc, BranchTaken_o, PHTindex_o, (pc / 4) % 32);
            end
        end
    endtask

    task automatic test_jal();
        do_reset();
        drive_e(0, 32'h10, 0, 1, 0, 32'h40, 5'd0);
        tick();
        PCF_i = 32'h10;
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b1 || BTBtarget_o !== 32'h40) begin
            n_fail++;
            $display("[TB] FAIL jal_hit: got taken=%0b target=%h expected taken=1 target=00000040",
                     BranchTaken_o, BTBtarget_o);
        end
    endtask

    task automatic test_beq();
        do_reset();
        drive_e(0, 32'h20, 1, 0, 1, 32'h80, 5'd8);
        tick();
        PCF_i = 32'h20;
        #1;
        n_checks++;
        if (PHTindex_o !== 5'd9) begin
            n_fail++;
            $display("[TB] FAIL beq_phtidx: got %0d expected 9", PHTindex_o);
        end
        n_checks++;
        if (BranchTaken_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL beq_taken: got %0b expected 0", BranchTaken_o);
        end
    endtask

    task automatic test_saturation();
        bit          pattern [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        bit          et;
        logic [4:0]  ei;
        logic [31:0] etg;
        logic [31:0] pc;
        do_reset();
        // Fill every BTB slot so any fetch PC with tag 0 hits.
        for (int i = 0; i < 32; i++) begin
            drive_e(0, 32'(i * 4), 1, 0, bit'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), 5'd20);
            tick();
        end
        for (int k = 0; k < 12; k++) begin
            drive_e(0, 32'h30, 1, 0, pattern[k], 32'h2000, 5'd3);
            tick();
            pc    = 32'((3 ^ m_ghr) * 4);
            PCF_i = pc;
            #1;
            model_predict(pc, et, ei, etg);
            n_checks++;
            if (PHTindex_o !== 5'd3 || BranchTaken_o !== et) begin
                n_fail++;
                $display("[TB] FAIL sat_step%0d: got taken=%0b idx=%0d expected taken=%0b idx=3",
                         k, BranchTaken_o, PHTindex_o, et);
            end
        end
    endtask

    task automatic test_alias();
        do_reset();
        drive_e(0, 32'h10, 0, 1, 0, 32'h40, 5'd0);
        tick();
        PCF_i = 32'h90;
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL alias_miss: got %0b expected 0", BranchTaken_o);
        end
        PCF_i = 32'h10;
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL alias_hit: got %0b expected 1", BranchTaken_o);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        drive_e(0, 32'h10, 0, 1, 0, 32'h40, 5'd0);
        tick();
        drive_e(1, 32'h20, 1, 0, 1, 32'h80, 5'd8);
        tick();
        PCF_i = 32'h20;
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b0 || PHTindex_o !== 5'd8) begin
            n_fail++;
            $display("[TB] FAIL rstprio_entry: got taken=%0b idx=%0d expected taken=0 idx=8",
                     BranchTaken_o, PHTindex_o);
        end
        PCF_i = 32'h10;
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstprio_cleared: got %0b expected 0", BranchTaken_o);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        PCF_i = 32'h40;
        drive_e(0, 32'h40, 0, 1, 0, 32'h100, 5'd0);
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL same_cycle_old: got %0b expected 0", BranchTaken_o);
        end
        tick();
        #1;
        n_checks++;
        if (BranchTaken_o !== 1'b1 || BTBtarget_o !== 32'h100) begin
            n_fail++;
            $display("[TB] FAIL same_cycle_new: got taken=%0b target=%h expected taken=1 target=00000100",
                     BranchTaken_o, BTBtarget_o);
        end
    endtask

    task automatic test_random();
        bit          et;
        logic [4:0]  ei;
        logic [31:0] etg;
        logic [31:0] pcf;
        logic [31:0] pce;
        int          kind;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pcf  = 32'(($urandom_range(0, 3) * 128) + ($urandom_range(0, 31) * 4));
            pce  = 32'(($urandom_range(0, 3) * 128) + ($urandom_range(0, 31) * 4));
            kind = $urandom_range(0, 3);
            PCF_i = pcf;
            drive_e($urandom_range(0, 63) == 0, pce, kind == 1 || kind == 2, kind == 3,
                    bit'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)));
            #1;
            model_predict(pcf, et, ei, etg);
            n_checks++;
            if (BranchTaken_o !== et || PHTindex_o !== ei || (et && BTBtarget_o !== etg)) begin
                n_fail++;
                $display("[TB] FAIL random%0d pc=%h: got taken=%0b idx=%0d tgt=%h expected taken=%0b idx=%0d tgt=%h",
                         n, pcf, BranchTaken_o, PHTindex_o, BTBtarget_o, et, ei, etg);
            end
            tick();
        end
    endtask

    initial begin
        drive_e(1, 0, 0, 0, 0, 0, 0);
        PCF_i = 32'h0;
        @(negedge clk);
        test_reset();
        test_jal();
        test_beq();
        test_saturation();
        test_alias();
        test_reset_priority();
        test_same_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
